// File: rtl/anf_fl_tex_block_fetch_if.sv
// Request, memory-read and decoder-side signal bundle for the ETC2 block fetcher.
// slave = fetcher view, master = surrounding logic view.
interface anf_fl_tex_block_fetch_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned PITCH_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_u;
  logic [COORD_W-1:0] req_v;
  logic [ADDR_W-1:0]  req_base;
  logic [PITCH_W-1:0] req_pitch;
  logic [4:0]         req_format;
  logic               inval;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_resp_valid;
  logic [127:0]       mem_resp_data;

  logic               dec_valid;
  logic               dec_ready;
  logic [127:0]       dec_data;
  logic [4:0]         dec_format;
  logic [1:0]         dec_x;
  logic [1:0]         dec_y;

  modport slave (
    input  req_valid, req_u, req_v, req_base, req_pitch, req_format, inval,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, dec_ready,
    output req_ready, mem_req_valid, mem_addr, dec_valid, dec_data, dec_format, dec_x, dec_y
  );

  modport master (
    output req_valid, req_u, req_v, req_base, req_pitch, req_format, inval,
    output mem_req_ready, mem_resp_valid, mem_resp_data, dec_ready,
    input  req_ready, mem_req_valid, mem_addr, dec_valid, dec_data, dec_format, dec_x, dec_y
  );
endinterface

// File: rtl/anf_fl_tex_block_fetch.sv
// Fetches the 128-bit ETC2 4x4 block holding a requested texel and hands it to the decoder.
// Define ANF_FL_TEX_BLOCK_CACHE_EN to add a single-entry block cache keyed on {address, format}.
module anf_fl_tex_block_fetch #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned PITCH_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  anf_fl_tex_block_fetch_if.slave bus
);

  // Block offset wide enough that the row*pitch product never truncates before the base add.
  localparam int unsigned BLK_W = COORD_W - 2;
  localparam int unsigned OFF_W = BLK_W + PITCH_W + 1 + 4;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, OUT} state_t;

  state_t             state, stateNext;
  logic               reqReadyQ, memReqValidQ, decValidQ;
  logic               reqReadyN, memReqValidN, decValidN;
  logic [ADDR_W-1:0]  memAddrQ;
  logic [127:0]       decDataQ;
  logic [4:0]         decFormatQ;
  logic [1:0]         decXQ, decYQ;

  logic               accept, fill, hit;
  logic [OFF_W-1:0]   blkOff;
  logic [ADDR_W-1:0]  blkAddr;
  logic [127:0]       hitData;

  assign blkOff  = (OFF_W'(bus.req_v[COORD_W-1:2]) * OFF_W'(bus.req_pitch)
                    + OFF_W'(bus.req_u[COORD_W-1:2])) << 4;
  assign blkAddr = bus.req_base + ADDR_W'(blkOff);

  assign accept = (state == IDLE) && reqReadyQ && bus.req_valid;
  assign fill   = (state == MEM_WAIT) && bus.mem_resp_valid;

`ifdef ANF_FL_TEX_BLOCK_CACHE_EN
  logic              cacheValid;
  logic [ADDR_W-1:0] cacheAddr;
  logic [4:0]        cacheFormat;
  logic [127:0]      cacheData;

  // An inval on the accept cycle forces a miss even if the tag matches.
  assign hit     = cacheValid && !bus.inval && (cacheAddr == blkAddr)
                   && (cacheFormat == bus.req_format);
  assign hitData = cacheData;

  always_ff @(posedge clk) begin
    if (rst) begin
      cacheValid  <= 1'b0;
      cacheAddr   <= '0;
      cacheFormat <= '0;
      cacheData   <= '0;
    end else begin
      if (fill) begin
        cacheValid  <= 1'b1;
        cacheAddr   <= memAddrQ;
        cacheFormat <= decFormatQ;
        cacheData   <= bus.mem_resp_data;
      end
      if (bus.inval) cacheValid <= 1'b0;
    end
  end
`else
  logic unusedInval;
  assign unusedInval = bus.inval;
  assign hit         = 1'b0;
  assign hitData     = '0;
`endif

  // State and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      reqReadyQ    <= 1'b0;
      memReqValidQ <= 1'b0;
      decValidQ    <= 1'b0;
    end else begin
      state        <= stateNext;
      reqReadyQ    <= reqReadyN;
      memReqValidQ <= memReqValidN;
      decValidQ    <= decValidN;
    end
  end

  always_comb begin
    stateNext    = state;
    reqReadyN    = 1'b0;
    memReqValidN = 1'b0;
    decValidN    = 1'b0;
    unique case (state)
      IDLE:     if (accept)             stateNext = hit ? OUT : MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready)  stateNext = MEM_WAIT;
      MEM_WAIT: if (bus.mem_resp_valid) stateNext = OUT;
      OUT:      if (bus.dec_ready)      stateNext = IDLE;
      default:                          stateNext = IDLE;
    endcase
    reqReadyN    = (stateNext == IDLE);
    memReqValidN = (stateNext == MEM_REQ);
    decValidN    = (stateNext == OUT);
  end

  // Request fields are captured at accept; block data on fill or cache hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      memAddrQ   <= '0;
      decDataQ   <= '0;
      decFormatQ <= '0;
      decXQ      <= '0;
      decYQ      <= '0;
    end else begin
      if (accept) begin
        memAddrQ   <= blkAddr;
        decFormatQ <= bus.req_format;
        decXQ      <= bus.req_u[1:0];
        decYQ      <= bus.req_v[1:0];
      end
      if (fill)              decDataQ <= bus.mem_resp_data;
      else if (accept && hit) decDataQ <= hitData;
    end
  end

  assign bus.req_ready     = reqReadyQ;
  assign bus.mem_req_valid = memReqValidQ;
  assign bus.mem_addr      = memAddrQ;
  assign bus.dec_valid     = decValidQ;
  assign bus.dec_data      = decDataQ;
  assign bus.dec_format    = decFormatQ;
  assign bus.dec_x         = decXQ;
  assign bus.dec_y         = decYQ;

endmodule

// File: tb/tb_anf_fl_tex_block_fetch.sv
// Self-checking bench for anf_fl_tex_block_fetch against a transaction-level block/cache model.
// Expected hit behaviour follows ANF_FL_TEX_BLOCK_CACHE_EN.
module tb_anf_fl_tex_block_fetch;

`ifdef ANF_FL_TEX_BLOCK_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   memHs;

  // Model of the single cached block.
  bit           cValid;
  logic [31:0]  cAddr;
  logic [4:0]   cFmt;
  logic [127:0] cData;

  anf_fl_tex_block_fetch_if #(.ADDR_W(32), .COORD_W(12), .PITCH_W(8)) ifc ();

  anf_fl_tex_block_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ifc.mem_req_valid === 1'b1 && ifc.mem_req_ready === 1'b1) memHs <= memHs + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete request: accept, optional fetch, decoder handoff; checks along the way.
  task automatic run_txn(input logic [11:0] u, input logic [11:0] v, input logic [31:0] base,
                         input logic [7:0] pitch, input logic [4:0] fmt, input int memStall,
                         input int respGap, input int decStall, input bit invalAcc,
                         input string tag);
    longint unsigned off;
    logic [31:0]  expAddr;
    logic [127:0] expData;
    bit           expHit;
    int           hs0;
    int           n;
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_wait got=%b exp=1", tag, ifc.req_ready); return;
    end
    off     = ((longint'(v) / 4) * longint'(pitch) + longint'(u) / 4) * 16;
    expAddr = 32'(longint'(base) + off);
    expHit  = CACHE_ON && cValid && !invalAcc && (cAddr == expAddr) && (cFmt == fmt);
    hs0     = memHs;
    ifc.req_valid = 1'b1; ifc.req_u = u; ifc.req_v = v; ifc.req_base = base;
    ifc.req_pitch = pitch; ifc.req_format = fmt; ifc.inval = invalAcc;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0; ifc.inval = 1'b0;
    if (invalAcc) cValid = 1'b0;
    checks++;
    if (ifc.req_ready !== 1'b0) begin
      failures++; $display("FAIL %s req_ready_after_accept got=%b exp=0", tag, ifc.req_ready);
    end
    if (expHit) begin
      expData = cData;
      checks++;
      if (ifc.mem_req_valid !== 1'b0) begin
        failures++; $display("FAIL %s hit_mem_req got=%b exp=0", tag, ifc.mem_req_valid);
      end
    end else begin
      checks++;
      if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== expAddr || ifc.dec_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s miss_issue got valid=%b addr=%h dec_valid=%b exp valid=1 addr=%h dec_valid=0",
                 tag, ifc.mem_req_valid, ifc.mem_addr, ifc.dec_valid, expAddr);
      end
      for (int i = 0; i < memStall; i++) begin
        ifc.mem_req_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== expAddr || ifc.req_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s mem_stall got valid=%b addr=%h req_ready=%b exp valid=1 addr=%h req_ready=0",
                   tag, ifc.mem_req_valid, ifc.mem_addr, ifc.req_ready, expAddr);
        end
      end
      ifc.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      ifc.mem_req_ready = 1'b0;
      checks++;
      if (ifc.mem_req_valid !== 1'b0) begin
        failures++; $display("FAIL %s mem_req_drop got=%b exp=0", tag, ifc.mem_req_valid);
      end
      for (int i = 0; i < respGap; i++) begin
        @(posedge clk); #1;
        checks++;
        if (ifc.dec_valid !== 1'b0) begin
          failures++; $display("FAIL %s dec_early got=%b exp=0", tag, ifc.dec_valid);
        end
      end
      expData = rand128();
      ifc.mem_resp_valid = 1'b1; ifc.mem_resp_data = expData;
      @(posedge clk); #1;
      ifc.mem_resp_valid = 1'b0; ifc.mem_resp_data = rand128();
      cValid = 1'b1; cAddr = expAddr; cFmt = fmt; cData = expData;
    end
    checks++;
    if (ifc.dec_valid !== 1'b1 || ifc.dec_data !== expData || ifc.dec_x !== u[1:0] ||
        ifc.dec_y !== v[1:0] || ifc.dec_format !== fmt) begin
      failures++;
      $display("FAIL %s dec_out got v=%b d=%h x=%0d y=%0d f=%0d exp v=1 d=%h x=%0d y=%0d f=%0d",
               tag, ifc.dec_valid, ifc.dec_data, ifc.dec_x, ifc.dec_y, ifc.dec_format,
               expData, u[1:0], v[1:0], fmt);
    end
    for (int i = 0; i < decStall; i++) begin
      ifc.req_valid = 1'b1; ifc.req_u = 12'($urandom); ifc.req_v = 12'($urandom);
      ifc.req_format = 5'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ifc.req_ready !== 1'b0 || ifc.dec_valid !== 1'b1 || ifc.dec_data !== expData ||
          ifc.dec_x !== u[1:0] || ifc.dec_y !== v[1:0] || ifc.dec_format !== fmt) begin
        failures++;
        $display("FAIL %s dec_stall got req_ready=%b v=%b d=%h x=%0d y=%0d f=%0d exp req_ready=0 v=1 d=%h",
                 tag, ifc.req_ready, ifc.dec_valid, ifc.dec_data, ifc.dec_x, ifc.dec_y,
                 ifc.dec_format, expData);
      end
    end
    ifc.req_valid = 1'b0;
    ifc.dec_ready = 1'b1;
    @(posedge clk); #1;
    ifc.dec_ready = 1'b0;
    checks++;
    if (ifc.dec_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got dec_valid=%b req_ready=%b exp dec_valid=0 req_ready=1",
               tag, ifc.dec_valid, ifc.req_ready);
    end
    checks++;
    if (memHs - hs0 !== (expHit ? 0 : 1)) begin
      failures++; $display("FAIL %s mem_req_count got=%0d exp=%0d", tag, memHs - hs0, expHit ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifc.req_ready !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.mem_addr !== 32'h0 ||
        ifc.dec_valid !== 1'b0 || ifc.dec_data !== 128'h0 || ifc.dec_format !== 5'h0 ||
        ifc.dec_x !== 2'h0 || ifc.dec_y !== 2'h0) begin
      failures++;
      $display("FAIL reset_outputs got rr=%b mv=%b ma=%h dv=%b dd=%h df=%h dx=%h dy=%h exp all 0",
               ifc.req_ready, ifc.mem_req_valid, ifc.mem_addr, ifc.dec_valid, ifc.dec_data,
               ifc.dec_format, ifc.dec_x, ifc.dec_y);
    end
    rst = 1'b0;
    cValid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_idle_ready got=%b exp=1", ifc.req_ready);
    end
  endtask

  task automatic test_single_miss();
    run_txn(12'd9, 12'd6, 32'h1000, 8'd4, 5'd3, 0, 3, 0, 1'b0, "single_miss");
  endtask

  task automatic test_mem_backpressure();
    run_txn(12'd33, 12'd17, 32'h0004_2000, 8'd20, 5'd7, 5, 1, 0, 1'b0, "mem_backpressure");
  endtask

  task automatic test_dec_backpressure();
    run_txn(12'd2, 12'd3, 32'h0000_8000, 8'd2, 5'd1, 0, 0, 4, 1'b0, "dec_backpressure");
  endtask

  task automatic test_cache();
    run_txn(12'd9, 12'd6, 32'h1000, 8'd4, 5'd3, 0, 2, 0, 1'b0, "cache_fill");
    run_txn(12'd10, 12'd5, 32'h1000, 8'd4, 5'd3, 0, 0, 2, 1'b0, "cache_hit");
    run_txn(12'd10, 12'd5, 32'h1000, 8'd4, 5'd4, 0, 1, 0, 1'b0, "cache_fmt_miss");
  endtask

  task automatic test_inval();
    run_txn(12'd9, 12'd6, 32'h1000, 8'd4, 5'd3, 0, 0, 0, 1'b0, "inval_fill");
    ifc.inval = 1'b1;
    @(posedge clk); #1;
    ifc.inval = 1'b0;
    cValid = 1'b0;
    run_txn(12'd8, 12'd7, 32'h1000, 8'd4, 5'd3, 0, 0, 0, 1'b0, "inval_pulse_refetch");
    run_txn(12'd11, 12'd4, 32'h1000, 8'd4, 5'd3, 0, 0, 0, 1'b1, "inval_at_accept");
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < 5) begin
      @(posedge clk); #1; n++;
    end
    ifc.req_valid = 1'b1; ifc.req_u = 12'd4; ifc.req_v = 12'd4; ifc.req_base = 32'h2000;
    ifc.req_pitch = 8'd2; ifc.req_format = 5'd9;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0; ifc.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    ifc.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ifc.req_ready !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.mem_addr !== 32'h0 ||
        ifc.dec_valid !== 1'b0 || ifc.dec_data !== 128'h0 || ifc.dec_format !== 5'h0) begin
      failures++;
      $display("FAIL midfetch_reset got rr=%b mv=%b ma=%h dv=%b dd=%h df=%h exp all 0",
               ifc.req_ready, ifc.mem_req_valid, ifc.mem_addr, ifc.dec_valid, ifc.dec_data,
               ifc.dec_format);
    end
    rst = 1'b0;
    cValid = 1'b0;
    ifc.mem_resp_valid = 1'b1; ifc.mem_resp_data = rand128();
    @(posedge clk); #1;
    ifc.mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ifc.dec_valid !== 1'b0 || ifc.mem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stray_resp got dec_valid=%b mem_req_valid=%b exp 0 0",
                 ifc.dec_valid, ifc.mem_req_valid);
      end
      @(posedge clk); #1;
    end
    run_txn(12'd4, 12'd4, 32'h2000, 8'd2, 5'd9, 0, 1, 0, 1'b0, "after_reset_fetch");
  endtask

  task automatic test_addr_wrap();
    run_txn(12'd4, 12'd0, 32'hFFFF_FFF0, 8'd1, 5'd2, 1, 0, 0, 1'b0, "addr_wrap");
  endtask

  task automatic test_random();
    logic [11:0] u, v, lu, lv;
    logic [31:0] base, lbase;
    logic [7:0]  pitch, lpitch;
    logic [4:0]  fmt, lfmt;
    lu = 12'd0; lv = 12'd0; lbase = 32'h0; lpitch = 8'd1; lfmt = 5'd0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        u = {lu[11:2], 2'($urandom)}; v = {lv[11:2], 2'($urandom)};
        base = lbase; pitch = lpitch;
        fmt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : lfmt;
      end else begin
        u = 12'($urandom); v = 12'($urandom);
        base = $urandom & 32'hFFFF_FFF0; pitch = 8'($urandom_range(1, 255));
        fmt = 5'($urandom);
      end
      run_txn(u, v, base, pitch, fmt, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), ($urandom_range(0, 7) == 0), "random");
      lu = u; lv = v; lbase = base; lpitch = pitch; lfmt = fmt;
    end
  endtask

  initial begin
    checks = 0; failures = 0; memHs = 0;
    cValid = 1'b0; cAddr = '0; cFmt = '0; cData = '0;
    rst = 1'b1;
    ifc.req_valid = 1'b0; ifc.req_u = '0; ifc.req_v = '0; ifc.req_base = '0;
    ifc.req_pitch = '0; ifc.req_format = '0; ifc.inval = 1'b0;
    ifc.mem_req_ready = 1'b0; ifc.mem_resp_valid = 1'b0; ifc.mem_resp_data = '0;
    ifc.dec_ready = 1'b0;
    test_reset();
    test_single_miss();
    test_mem_backpressure();
    test_dec_backpressure();
    test_cache();
    test_inval();
    test_reset_mid_fetch();
    test_addr_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anf_fl_tex_block_fetch.md
Name: anf_fl_tex_block_fetch

Overview:
- Upstream feeder for the ETC2 texture block decoder.
- Accepts one texel sample request per handshake, computes the address of the 4x4 compressed block that holds the texel, and fetches the 128-bit block over a simple memory read port.
- Presents block data, format and the in-block texel position (xTexel/yTexel) to the decoder through a valid/ready interface.
- Optionally reuses the last fetched block so that runs of texels from the same block skip memory.

Parameters:
- ADDR_W, 32, byte address width of the memory port and the texture base address.
- COORD_W, 12, width of the u/v texel coordinates.
- PITCH_W, 8, width of the row pitch, given in blocks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  sample request valid.
- req_ready  out  1  block can accept a request.
- req_u  in  COORD_W  texel x coordinate.
- req_v  in  COORD_W  texel y coordinate.
- req_base  in  ADDR_W  texture base byte address; 16-byte aligned.
- req_pitch  in  PITCH_W  blocks per texture row.
- req_format  in  5  texture format code; passed to the decoder unchanged.
- inval  in  1  invalidates the cached block (texture rebinding).
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  block byte address.
- mem_resp_valid  in  1  read data valid; one beat per request.
- mem_resp_data  in  128  compressed block.
- dec_valid  out  1  decoder inputs valid.
- dec_ready  in  1  decoder/consumer accepts.
- dec_data  out  128  block to decode.
- dec_format  out  5  format.
- dec_x  out  2  xTexel = u[1:0].
- dec_y  out  2  yTexel = v[1:0].

Behaviour:
- Synchronous active-high reset on clk.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Cache-valid flag is cleared.
  - Reset mid-fetch abandons the transaction. Any later mem_resp_valid pulse arriving in IDLE is ignored.
- Address arithmetic, computed at request accept:
  - blk_addr = req_base + (((v>>2) * req_pitch + (u>>2)) << 4).
  - The product is a full-width unsigned multiply; the sum is truncated to ADDR_W and wraps modulo 2^ADDR_W.
- The request is latched at accept: blk_addr, format, u[1:0], v[1:0].
- req_ready = 1 only in IDLE.
- FSM states:
  - IDLE: on req_valid go to MEM_REQ, or to OUT on a cache hit.
  - MEM_REQ: mem_req_valid=1 with a stable mem_addr. Go to MEM_WAIT on the cycle mem_req_ready=1.
  - MEM_WAIT: on mem_resp_valid, capture data into the block register and go to OUT.
  - OUT: dec_valid=1; dec_* outputs are held stable until dec_ready. On dec_ready go to IDLE.
- Latency:
  - Miss: mem_req_valid rises the cycle after accept. dec_valid rises the cycle after mem_resp_valid.
  - Hit (feature on): dec_valid rises the cycle after accept.
- mem_resp_valid in any state other than MEM_WAIT is ignored.
- One outstanding memory request at most. mem_req_valid never drops before mem_req_ready.
- Throughput is at most one request per 2 cycles; IDLE is always visited between requests.
- inval clears the cache-valid flag on the cycle it is high.
  - If inval coincides with accept, the accepted request is treated as a miss.
  - inval never affects an in-flight fetch or OUT data.

Optional Feature:
- Macro: ANF_FL_TEX_BLOCK_CACHE_EN.
- Defined:
  - A single-entry cache holding tag {blk_addr, format} and the 128-bit data. A fetch completion writes the entry and sets valid.
  - An accept whose tag matches while valid=1 goes straight to OUT with the cached data; no memory traffic.
- Undefined:
  - Every request fetches. inval is accepted but has no effect.
  - No tag storage is synthesized.

Test Plan:
- Reset then single miss:
  - Stimulus: base=0x1000, pitch=4, u=9, v=6, format=3.
  - Response: mem_addr=0x1000+((1*4+2)<<4)=0x1060 the cycle after accept; respond data=D0 after 3 cycles.
  - Required: dec_data=D0, dec_x=1, dec_y=2, dec_format=3 the cycle after the response.
- Memory backpressure:
  - Stimulus: hold mem_req_ready=0 for 5 cycles.
  - Required: mem_req_valid and mem_addr stable throughout; req_ready=0; exactly one request issued.
- Decoder backpressure:
  - Stimulus: dec_ready=0 for 4 cycles in OUT.
  - Required: dec_* stable; req_ready=0; new req_valid not accepted until after dec_ready.
- Cache hit/miss (feature on):
  - Stimulus: second request u=10, v=5, same block.
  - Required: no mem_req_valid; dec_valid the cycle after accept, with the same data and dec_x=2, dec_y=1.
  - Stimulus: same block with format=4.
  - Required: miss, fetch issued.
- inval and reset:
  - Stimulus: inval pulse, then a request for the cached block.
  - Required: fetch issued.
  - Stimulus: assert rst during MEM_WAIT, then a stray mem_resp_valid.
  - Required: outputs 0, no dec_valid, next request fetches.
- Address wrap:
  - Stimulus: base=0xFFFFFFF0, pitch=1, u=4, v=0.
  - Required: mem_addr=0x00000000.
